// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 inverse round controller.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  localparam int AES_NR        = 10;
  localparam int AES_KEY_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_ctrl_st_t;

endpackage

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption scheduler driving an external inverse-round datapath.
// Defining AES_INV_BLK_CNT_EN adds a saturating completed-block counter on blk_cnt.
// state | meaning
// IDLE  | ready for a ciphertext; initial AddRoundKey applied on accept
// ROUND | one datapath pass per round, rnd NR-1 down to 0
// DONE  | plaintext held on out_data until the consumer takes it
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int DP_LAT = 0,
  parameter int NR     = AES_NR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  aes_block_t               in_data,
  output logic [AES_KEY_IDX_W-1:0] key_idx,
  input  aes_block_t               key_data,
  output aes_block_t               dp_din,
  output aes_block_t               dp_key,
  output logic                     dp_last,
  input  aes_block_t               dp_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output aes_block_t               out_data
`ifdef AES_INV_BLK_CNT_EN
  ,
  output logic [31:0]              blk_cnt
`endif
);

  localparam logic [1:0]               LAT_LAST  = 2'(DP_LAT);
  localparam logic [AES_KEY_IDX_W-1:0] RND_FIRST = AES_KEY_IDX_W'(NR - 1);
  localparam logic [AES_KEY_IDX_W-1:0] KEY_INIT  = AES_KEY_IDX_W'(NR);

  aes_ctrl_st_t               st_q, st_d;
  logic [AES_KEY_IDX_W-1:0]   rnd_q, rnd_d;
  logic [1:0]                 wait_cnt_q, wait_cnt_d;
  aes_block_t                 blk_q, blk_d;

  assign dp_key = key_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      rnd_q      <= RND_FIRST;
      wait_cnt_q <= '0;
      blk_q      <= '0;
    end else begin
      st_q       <= st_d;
      rnd_q      <= rnd_d;
      wait_cnt_q <= wait_cnt_d;
      blk_q      <= blk_d;
    end
  end

  // Outputs are forced to their idle values while rst is high so no handshake leaks out.
  always_comb begin
    st_d       = st_q;
    rnd_d      = rnd_q;
    wait_cnt_d = wait_cnt_q;
    blk_d      = blk_q;
    in_ready   = 1'b0;
    key_idx    = KEY_INIT;
    dp_din     = '0;
    dp_last    = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    if (!rst) begin
      case (st_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            blk_d      = in_data ^ key_data;
            rnd_d      = RND_FIRST;
            wait_cnt_d = '0;
            st_d       = ROUND;
          end
        end
        ROUND: begin
          dp_din  = blk_q;
          key_idx = rnd_q;
          dp_last = (rnd_q == '0);
          if (wait_cnt_q == LAT_LAST) begin
            blk_d      = dp_dout;
            wait_cnt_d = '0;
            if (rnd_q == '0) st_d  = DONE;
            else             rnd_d = rnd_q - 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 2'd1;
          end
        end
        DONE: begin
          out_valid = 1'b1;
          out_data  = blk_q;
          if (out_ready) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
  end

`ifdef AES_INV_BLK_CNT_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_valid && out_ready && (blk_cnt_q != 32'hFFFF_FFFF)) blk_cnt_d = blk_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) blk_cnt_q <= '0;
    else     blk_cnt_q <= blk_cnt_d;
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl: one DUT with a combinational datapath model,
// one with a 3-stage pipelined model; AES math is rebuilt from GF(2^8) arithmetic.
module tb_aes_inv_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  logic         in_valid0, in_ready0, dp_last0, out_valid0, out_ready0;
  logic [127:0] in_data0, key_data0, dp_din0, dp_key0, dp_dout0, out_data0;
  logic [3:0]   key_idx0;
  logic         in_valid3, in_ready3, dp_last3, out_valid3, out_ready3;
  logic [127:0] in_data3, key_data3, dp_din3, dp_key3, dp_dout3, out_data3;
  logic [3:0]   key_idx3;
  logic [127:0] p1, p2, p3;
`ifdef AES_INV_BLK_CNT_EN
  logic [31:0]  blk_cnt0, blk_cnt3;
`endif

  logic [127:0] rk [0:15];
  logic [127:0] CT1, PT1, CT2, PT2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_round_ctrl #(.DP_LAT(0), .NR(10)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .key_idx(key_idx0), .key_data(key_data0), .dp_din(dp_din0), .dp_key(dp_key0),
    .dp_last(dp_last0), .dp_dout(dp_dout0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0)
`ifdef AES_INV_BLK_CNT_EN
    , .blk_cnt(blk_cnt0)
`endif
  );

  aes_inv_round_ctrl #(.DP_LAT(3), .NR(10)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .key_idx(key_idx3), .key_data(key_data3), .dp_din(dp_din3), .dp_key(dp_key3),
    .dp_last(dp_last3), .dp_dout(dp_dout3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3)
`ifdef AES_INV_BLK_CNT_EN
    , .blk_cnt(blk_cnt3)
`endif
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gm(p, p);
      r = gm(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] t, o;
    logic [7:0]   a0, a1, a2, a3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[8*(r+4*c) +: 8] = isbox(s[8*(r+4*((c-r+4)%4)) +: 8]);
    t = t ^ k;
    if (last) return t;
    for (int c = 0; c < 4; c++) begin
      a0 = t[8*(4*c) +: 8];   a1 = t[8*(4*c+1) +: 8];
      a2 = t[8*(4*c+2) +: 8]; a3 = t[8*(4*c+3) +: 8];
      o[8*(4*c) +: 8]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
      o[8*(4*c+1) +: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
      o[8*(4*c+2) +: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
      o[8*(4*c+3) +: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
    end
    return o;
  endfunction

  // Forward cipher, used only to produce a second ciphertext with a known plaintext
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s, t, o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk[0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)%4)) +: 8]);
      o = t;
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[8*(4*c) +: 8];   a1 = t[8*(4*c+1) +: 8];
          a2 = t[8*(4*c+2) +: 8]; a3 = t[8*(4*c+3) +: 8];
          o[8*(4*c) +: 8]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          o[8*(4*c+1) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          o[8*(4*c+3) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = o ^ rk[rd];
    end
    return s;
  endfunction

  always_comb key_data0 = rk[key_idx0];
  always_comb key_data3 = rk[key_idx3];
  assign dp_dout0 = inv_round(dp_din0, dp_key0, dp_last0);

  always @(posedge clk) begin
    p1 <= inv_round(dp_din3, dp_key3, dp_last3);
    p2 <= p1;
    p3 <= p2;
  end
  assign dp_dout3 = p3;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input logic [127:0] ct, input logic [127:0] pt, input string tag);
    int n, acc;
    out_ready0 = 1'b1;
    in_valid0  = 1'b1;
    in_data0   = ct;
    n = 0;
    while (!in_ready0 && n < 50) begin tick(); n++; end
    chk({tag, "_acc"}, 128'(in_ready0), 128'd1);
    acc = cyc;
    tick();
    in_valid0 = 1'b0;
    in_data0  = '0;
    chk({tag, "_busy"}, 128'(in_ready0), 128'd0);
    chk({tag, "_k9"}, 128'(key_idx0), 128'd9);
    n = 0;
    while (!out_valid0 && n < 100) begin tick(); n++; end
    chk({tag, "_lat"}, 128'(cyc - acc), 128'd11);
    chk({tag, "_pt"}, out_data0, pt);
    tick();
    chk({tag, "_idle"}, 128'(in_ready0), 128'd1);
    chk({tag, "_vlo"}, 128'(out_valid0), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]  w [0:43];
    logic [127:0] kb, st;
    logic [127:0] got [0:1];
    logic [31:0]  t;
    logic [7:0]   rc;
    int           acc [0:1];
    int           n, nacc, nout, ek, a;
    logic         seen;

    rst = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;

    kb = bswap(128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 4; i++)
      w[i] = {kb[32*i +: 8], kb[32*i+8 +: 8], kb[32*i+16 +: 8], kb[32*i+24 +: 8]};
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          rk[r][8*(4*c+j) +: 8] = w[4*r+c][8*(3-j) +: 8];

    CT1 = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    PT1 = bswap(128'h00112233445566778899aabbccddeeff);
    PT2 = bswap(128'hdeadbeef0123456789abcdeff0e1d2c3);
    CT2 = encrypt(PT2);

    // reset state
    repeat (3) tick();
    chk("rst_in_ready", 128'(in_ready0), 128'd0);
    chk("rst_out_valid", 128'(out_valid0), 128'd0);
    chk("rst_key_idx", 128'(key_idx0), 128'd10);
    chk("rst_dp_din", dp_din0, 128'd0);
    chk("rst_dp_last", 128'(dp_last0), 128'd0);
    chk("rst_out_data", out_data0, 128'd0);
    chk("rst_key_idx3", 128'(key_idx3), 128'd10);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 128'(in_ready0), 128'd1);

    // FIPS-197 C.1 with a combinational datapath
    run0(CT1, PT1, "t1");

    // backpressure for 20 cycles
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    in_data0   = CT1;
    n = 0;
    while (!in_ready0 && n < 50) begin tick(); n++; end
    tick();
    in_valid0 = 1'b0;
    n = 0;
    while (!out_valid0 && n < 100) begin tick(); n++; end
    chk("bp_valid", 128'(out_valid0), 128'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_data", out_data0, PT1);
      chk("bp_in_ready", 128'(in_ready0), 128'd0);
      chk("bp_hold", 128'(out_valid0), 128'd1);
    end
    out_ready0 = 1'b1;
    tick();
    chk("bp_vlo", 128'(out_valid0), 128'd0);
    chk("bp_idle", 128'(in_ready0), 128'd1);

    // back-to-back with in_valid held high
    in_valid0 = 1'b1;
    in_data0  = CT1;
    nacc = 0;
    nout = 0;
    for (int i = 0; i < 80 && nout < 2; i++) begin
      if (out_valid0) begin
        got[nout] = out_data0;
        chk("b2b_rdy_done", 128'(in_ready0), 128'd0);
        nout++;
      end
      if (in_ready0 && in_valid0 && nacc < 2) begin
        acc[nacc] = cyc;
        nacc++;
      end
      tick();
      if (nacc == 1) in_data0 = CT2;
      else if (nacc >= 2) in_valid0 = 1'b0;
    end
    in_valid0 = 1'b0;
    chk("b2b_nout", 128'(nout), 128'd2);
    chk("b2b_nacc", 128'(nacc), 128'd2);
    chk("b2b_pt0", got[0], PT1);
    chk("b2b_pt1", got[1], PT2);
    chk("b2b_spacing", 128'(acc[1] - acc[0]), 128'd12);

    // reset mid-round
    in_valid0 = 1'b1;
    in_data0  = CT2;
    n = 0;
    while (!in_ready0 && n < 50) begin tick(); n++; end
    tick();
    in_valid0 = 1'b0;
    n = 0;
    while (key_idx0 != 4'd5 && n < 20) begin tick(); n++; end
    chk("mid_k5", 128'(key_idx0), 128'd5);
    rst = 1'b1;
    tick();
    chk("mid_in_ready", 128'(in_ready0), 128'd0);
    chk("mid_out_valid", 128'(out_valid0), 128'd0);
    chk("mid_key_idx", 128'(key_idx0), 128'd10);
    chk("mid_dp_din", dp_din0, 128'd0);
    chk("mid_dp_last", 128'(dp_last0), 128'd0);
    chk("mid_out_data", out_data0, 128'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid0) seen = 1'b1;
      tick();
    end
    chk("mid_no_valid", 128'(seen), 128'd0);
    run0(CT2, PT2, "t5");

    // DP_LAT=3 with a pipelined datapath
    in_valid3 = 1'b1;
    in_data3  = CT1;
    n = 0;
    while (!in_ready3 && n < 50) begin tick(); n++; end
    chk("t2_acc", 128'(in_ready3), 128'd1);
    chk("t2_kidx_acc", 128'(key_idx3), 128'd10);
    a = cyc;
    tick();
    in_valid3 = 1'b0;
    st = CT1 ^ rk[10];
    for (int k = 1; k <= 40; k++) begin
      ek = 9 - (k - 1) / 4;
      chk("t2_kidx", 128'(key_idx3), 128'(ek));
      chk("t2_last", 128'(dp_last3), 128'(ek == 0));
      chk("t2_din", dp_din3, st);
      chk("t2_vlo", 128'(out_valid3), 128'd0);
      if ((k - 1) % 4 == 3) st = inv_round(st, rk[ek], ek == 0);
      tick();
    end
    chk("t2_valid41", 128'(out_valid3), 128'd1);
    chk("t2_cycle", 128'(cyc - a), 128'd41);
    chk("t2_pt", out_data3, PT1);
    tick();
    chk("t2_idle", 128'(in_ready3), 128'd1);

`ifdef AES_INV_BLK_CNT_EN
    rst = 1'b1;
    tick();
    chk("cnt_rst0", 128'(blk_cnt0), 128'd0);
    rst = 1'b0;
    run0(CT1, PT1, "c1");
    run0(CT2, PT2, "c2");
    run0(CT1, PT1, "c3");
    chk("cnt_three", 128'(blk_cnt0), 128'd3);
    rst = 1'b1;
    tick();
    chk("cnt_rst1", 128'(blk_cnt0), 128'd0);
    rst = 1'b0;
    force u0.blk_cnt_q = 32'hFFFF_FFFF;
    tick();
    release u0.blk_cnt_q;
    run0(CT1, PT1, "c4");
    chk("cnt_sat", 128'(blk_cnt0), 128'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
